// File: rtl/qspi_arbiter_if.sv
// qspi_arbiter_if
// Request bus between the arbiter and the QSPI memory controller.
// Parameter:
//   CHIP_SELECTS  number of chip-select lines
// Signals:
//   valid     request strobe toward the controller
//   addr      24-bit QSPI byte address
//   wdata     write data
//   wstrb     byte write strobes (0 = read)
//   xfer_len  burst length minus one, in words
//   ce        chip selects
//   ready     controller word-done strobe
//   rdata     controller read data
// Modports: master (arbiter side), slave (controller side).
interface qspi_arbiter_if #(
  parameter int unsigned CHIP_SELECTS = 2
) ();
  logic                    valid;
  logic [23:0]             addr;
  logic [15:0]             wdata;
  logic [1:0]              wstrb;
  logic [3:0]              xfer_len;
  logic [CHIP_SELECTS-1:0] ce;
  logic                    ready;
  logic [15:0]             rdata;

  modport master (
    output valid, addr, wdata, wstrb, xfer_len, ce,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb, xfer_len, ce,
    output ready, rdata
  );
endinterface

// File: rtl/qspi_arbiter.sv
// qspi_arbiter
// Shares one QSPI controller between the debug port, the LISA1 fetch port and the
// LISA2 data port. One requester owns the controller for a whole burst; LISA
// addresses are relocated by their base, and ready/rdata are routed back.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   i_dbg_*  / o_dbg_ready  debug request (24-bit address, passed unmodified)
//   i_l1_*   / o_l1_ready   LISA1 read-only fetch request + base/chip select
//   i_l2_*   / o_l2_ready   LISA2 request + base/chip select
//   o_rdata                 controller read data broadcast
//   o_busy                  high while a burst is granted
//   qspi                    controller-side request bus (master modport)
module qspi_arbiter #(
  parameter int unsigned CHIP_SELECTS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_dbg_valid,
  input  logic [23:0]             i_dbg_addr,
  input  logic [15:0]             i_dbg_wdata,
  input  logic [1:0]              i_dbg_wstrb,
  input  logic [3:0]              i_dbg_xfer_len,
  input  logic [CHIP_SELECTS-1:0] i_dbg_ce,
  output logic                    o_dbg_ready,
  input  logic                    i_l1_valid,
  input  logic [15:0]             i_l1_addr,
  input  logic [3:0]              i_l1_xfer_len,
  output logic                    o_l1_ready,
  input  logic [15:0]             i_l1_base_addr,
  input  logic [CHIP_SELECTS-1:0] i_l1_ce,
  input  logic                    i_l2_valid,
  input  logic [15:0]             i_l2_addr,
  input  logic [15:0]             i_l2_wdata,
  input  logic [1:0]              i_l2_wstrb,
  input  logic [3:0]              i_l2_xfer_len,
  output logic                    o_l2_ready,
  input  logic [15:0]             i_l2_base_addr,
  input  logic [CHIP_SELECTS-1:0] i_l2_ce,
  output logic [15:0]             o_rdata,
  output logic                    o_busy,
  qspi_arbiter_if.master          qspi
);

  typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;
  typedef enum logic [1:0] {GntNone, GntDbg, GntL1, GntL2} gnt_e;

  state_e     r_state;
  gnt_e       r_gnt;
  logic [3:0] r_count;
  logic       r_last_l2;  // 1: LISA2 was the last LISA port granted

  gnt_e                    w_gnt_next;
  logic                    w_in_busy;
  logic                    w_sel_valid;
  logic [23:0]             w_sel_addr;
  logic [15:0]             w_sel_wdata;
  logic [1:0]              w_sel_wstrb;
  logic [3:0]              w_sel_len;
  logic [CHIP_SELECTS-1:0] w_sel_ce;
  logic [23:0]             w_l1_addr;
  logic [23:0]             w_l2_addr;
  logic                    w_fire;

  // 24-bit relocation; carry out of bit 23 wraps.
  assign w_l1_addr = {i_l1_base_addr, 8'h00} + {8'h00, i_l1_addr};
  assign w_l2_addr = {i_l2_base_addr, 8'h00} + {8'h00, i_l2_addr};

  // Debug always wins; LISA ties go to the port not granted last.
  always_comb begin
    w_gnt_next = GntNone;
    if (i_dbg_valid) begin
      w_gnt_next = GntDbg;
    end else if (i_l1_valid && i_l2_valid) begin
      w_gnt_next = r_last_l2 ? GntL1 : GntL2;
    end else if (i_l1_valid) begin
      w_gnt_next = GntL1;
    end else if (i_l2_valid) begin
      w_gnt_next = GntL2;
    end
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    w_sel_len   = '0;
    w_sel_ce    = '0;
    case (r_gnt)
      GntDbg: begin
        w_sel_valid = i_dbg_valid;
        w_sel_addr  = i_dbg_addr;
        w_sel_wdata = i_dbg_wdata;
        w_sel_wstrb = i_dbg_wstrb;
        w_sel_len   = i_dbg_xfer_len;
        w_sel_ce    = i_dbg_ce;
      end
      GntL1: begin
        w_sel_valid = i_l1_valid;
        w_sel_addr  = w_l1_addr;
        w_sel_len   = i_l1_xfer_len;
        w_sel_ce    = i_l1_ce;
      end
      GntL2: begin
        w_sel_valid = i_l2_valid;
        w_sel_addr  = w_l2_addr;
        w_sel_wdata = i_l2_wdata;
        w_sel_wstrb = i_l2_wstrb;
        w_sel_len   = i_l2_xfer_len;
        w_sel_ce    = i_l2_ce;
      end
      default: ;
    endcase
  end

  assign w_in_busy     = (r_state == StBusy);
  assign qspi.valid    = w_in_busy && w_sel_valid;
  assign qspi.addr     = w_in_busy ? w_sel_addr  : '0;
  assign qspi.wdata    = w_in_busy ? w_sel_wdata : '0;
  assign qspi.wstrb    = w_in_busy ? w_sel_wstrb : '0;
  assign qspi.xfer_len = w_in_busy ? w_sel_len   : '0;
  assign qspi.ce       = w_in_busy ? w_sel_ce    : '0;

  // A ready only counts while the granted request is live, so an abort issues none.
  assign w_fire      = qspi.valid && qspi.ready;
  assign o_dbg_ready = w_fire && (r_gnt == GntDbg);
  assign o_l1_ready  = w_fire && (r_gnt == GntL1);
  assign o_l2_ready  = w_fire && (r_gnt == GntL2);
  assign o_rdata     = qspi.rdata;
  assign o_busy      = w_in_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_gnt     <= GntNone;
      r_count   <= 4'd0;
      r_last_l2 <= 1'b1;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_gnt_next != GntNone) begin
            r_gnt   <= w_gnt_next;
            r_count <= 4'd0;
            r_state <= StBusy;
            if (w_gnt_next == GntL1) r_last_l2 <= 1'b0;
            if (w_gnt_next == GntL2) r_last_l2 <= 1'b1;
          end
        end
        StBusy: begin
          if (!w_sel_valid) begin
            r_state <= StGap;
          end else if (qspi.ready) begin
            r_count <= r_count + 4'd1;
            if (r_count == w_sel_len) r_state <= StGap;
          end
        end
        StGap: begin
          r_state <= StIdle;
          r_gnt   <= GntNone;
        end
        default: begin
          r_state <= StIdle;
          r_gnt   <= GntNone;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_arbiter.sv
// tb_qspi_arbiter
// Directed bench for qspi_arbiter; the bench plays the QSPI controller through
// the interface instance and checks against hand-computed values.
module tb_qspi_arbiter;
  localparam int unsigned CS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dbg_valid;
  logic [23:0]   dbg_addr;
  logic [15:0]   dbg_wdata;
  logic [1:0]    dbg_wstrb;
  logic [3:0]    dbg_xfer_len;
  logic [CS-1:0] dbg_ce;
  logic          dbg_ready;
  logic          l1_valid;
  logic [15:0]   l1_addr;
  logic [3:0]    l1_xfer_len;
  logic          l1_ready;
  logic [15:0]   l1_base_addr;
  logic [CS-1:0] l1_ce;
  logic          l2_valid;
  logic [15:0]   l2_addr;
  logic [15:0]   l2_wdata;
  logic [1:0]    l2_wstrb;
  logic [3:0]    l2_xfer_len;
  logic          l2_ready;
  logic [15:0]   l2_base_addr;
  logic [CS-1:0] l2_ce;
  logic [15:0]   rdata;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  qspi_arbiter_if #(.CHIP_SELECTS(CS)) qif ();

  qspi_arbiter #(.CHIP_SELECTS(CS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_dbg_valid    (dbg_valid),
    .i_dbg_addr     (dbg_addr),
    .i_dbg_wdata    (dbg_wdata),
    .i_dbg_wstrb    (dbg_wstrb),
    .i_dbg_xfer_len (dbg_xfer_len),
    .i_dbg_ce       (dbg_ce),
    .o_dbg_ready    (dbg_ready),
    .i_l1_valid     (l1_valid),
    .i_l1_addr      (l1_addr),
    .i_l1_xfer_len  (l1_xfer_len),
    .o_l1_ready     (l1_ready),
    .i_l1_base_addr (l1_base_addr),
    .i_l1_ce        (l1_ce),
    .i_l2_valid     (l2_valid),
    .i_l2_addr      (l2_addr),
    .i_l2_wdata     (l2_wdata),
    .i_l2_wstrb     (l2_wstrb),
    .i_l2_xfer_len  (l2_xfer_len),
    .o_l2_ready     (l2_ready),
    .i_l2_base_addr (l2_base_addr),
    .i_l2_ce        (l2_ce),
    .o_rdata        (rdata),
    .o_busy         (busy),
    .qspi           (qif)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int          exp_gnt [3] = '{1, 2, 1};
  logic [23:0] exp_addr;

  initial begin
    rst_n = 1'b0;
    dbg_valid = 0; dbg_addr = '0; dbg_wdata = '0; dbg_wstrb = '0; dbg_xfer_len = '0; dbg_ce = '0;
    l1_valid = 0; l1_addr = '0; l1_xfer_len = '0; l1_base_addr = '0; l1_ce = '0;
    l2_valid = 0; l2_addr = '0; l2_wdata = '0; l2_wstrb = '0; l2_xfer_len = '0;
    l2_base_addr = '0; l2_ce = '0;
    qif.ready = 1'b1;  // must be ignored outside BUSY
    qif.rdata = '0;

    // Reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_valid", qif.valid, 0);
    check("rst_addr", qif.addr, 0);
    check("rst_ce", qif.ce, 0);
    check("rst_readies", {dbg_ready, l1_ready, l2_ready}, 0);
    qif.ready = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // LISA1 single word with relocation
    l1_valid = 1; l1_base_addr = 16'h1234; l1_addr = 16'h0056; l1_xfer_len = 0; l1_ce = 2'b01;
    settle();
    check("s1_cycle_n_valid", qif.valid, 0);
    tick();
    check("s1_valid", qif.valid, 1);
    check("s1_addr", qif.addr, 24'h123456);
    check("s1_busy", busy, 1);
    check("s1_wdata", qif.wdata, 0);
    check("s1_wstrb", qif.wstrb, 0);
    check("s1_ce", qif.ce, 2'b01);
    qif.ready = 1; qif.rdata = 16'hA5C3;
    settle();
    check("s1_readies", {dbg_ready, l1_ready, l2_ready}, 3'b010);
    check("s1_rdata", rdata, 16'hA5C3);
    tick();
    qif.ready = 0; l1_valid = 0;
    settle();
    check("s1_gap_valid", qif.valid, 0);
    check("s1_gap_busy", busy, 0);
    tick();
    check("s1_idle_valid", qif.valid, 0);

    // dbg and l1 together: dbg first, l1 at M+3
    dbg_valid = 1; dbg_addr = 24'hABCDEF; dbg_wdata = 16'h1111; dbg_wstrb = 2'b01;
    dbg_xfer_len = 0; dbg_ce = 2'b10;
    l1_valid = 1; l1_base_addr = 16'h0100; l1_addr = 16'h0002; l1_xfer_len = 0;
    tick();
    check("s2_dbg_addr", qif.addr, 24'hABCDEF);
    check("s2_dbg_wdata", qif.wdata, 16'h1111);
    check("s2_dbg_ce", qif.ce, 2'b10);
    qif.ready = 1;
    settle();
    check("s2_dbg_readies", {dbg_ready, l1_ready, l2_ready}, 3'b100);
    tick();
    qif.ready = 0; dbg_valid = 0;
    settle();
    check("s2_m1_valid", qif.valid, 0);
    tick();
    check("s2_m2_valid", qif.valid, 0);
    tick();
    check("s2_m3_valid", qif.valid, 1);
    check("s2_l1_addr", qif.addr, 24'h010002);
    qif.ready = 1;
    settle();
    check("s2_l1_readies", {dbg_ready, l1_ready, l2_ready}, 3'b010);
    tick();
    qif.ready = 0; l1_valid = 0;
    tick();

    // Round robin after a fresh reset (l1 wins the first tie)
    rst_n = 0;
    tick();
    rst_n = 1;
    l1_valid = 1; l1_base_addr = 16'h2000; l1_addr = 16'h0010; l1_xfer_len = 1; l1_ce = 2'b01;
    l2_valid = 1; l2_base_addr = 16'h3000; l2_addr = 16'h0020; l2_xfer_len = 1; l2_ce = 2'b10;
    l2_wdata = 16'hBEEF; l2_wstrb = 2'b11;
    for (int b = 0; b < 3; b++) begin
      exp_addr = (exp_gnt[b] == 1) ? 24'h200010 : 24'h300020;
      tick();
      check("s3_addr", qif.addr, exp_addr);
      check("s3_wdata", qif.wdata, (exp_gnt[b] == 1) ? 16'h0000 : 16'hBEEF);
      qif.ready = 1;
      settle();
      check("s3_ready_w0", {l1_ready, l2_ready}, (exp_gnt[b] == 1) ? 2'b10 : 2'b01);
      tick();
      check("s3_second_word_valid", qif.valid, 1);
      check("s3_ready_w1", {l1_ready, l2_ready}, (exp_gnt[b] == 1) ? 2'b10 : 2'b01);
      tick();
      qif.ready = 0;
      settle();
      check("s3_gap_valid", qif.valid, 0);
      tick();
    end
    l1_valid = 0; l2_valid = 0;
    tick();

    // Relocation wrap
    l1_valid = 1; l1_base_addr = 16'hFFFF; l1_addr = 16'h0100; l1_xfer_len = 0;
    tick();
    check("s4_valid", qif.valid, 1);
    check("s4_wrap_addr", qif.addr, 24'h000000);
    qif.ready = 1;
    tick();
    qif.ready = 0; l1_valid = 0;
    tick();

    // LISA2 write aborted after two of four words
    l2_valid = 1; l2_base_addr = 16'h0040; l2_addr = 16'h0008; l2_wdata = 16'hCAFE;
    l2_wstrb = 2'b10; l2_xfer_len = 3; l2_ce = 2'b01;
    tick();
    check("s5_addr", qif.addr, 24'h004008);
    check("s5_wstrb", qif.wstrb, 2'b10);
    check("s5_len", qif.xfer_len, 3);
    qif.ready = 1;
    tick();
    tick();
    check("s5_busy_after_two", busy, 1);
    l2_valid = 0;
    settle();
    check("s5_abort_valid", qif.valid, 0);
    check("s5_abort_ready", l2_ready, 0);
    tick();
    check("s5_gap_busy", busy, 0);
    check("s5_gap_ready", l2_ready, 0);
    qif.ready = 0;
    tick();
    l2_valid = 1; l2_xfer_len = 0;
    tick();
    check("s5_regrant_busy", busy, 1);
    qif.ready = 1;
    settle();
    check("s5_regrant_ready", l2_ready, 1);
    tick();
    check("s5_count_cleared", busy, 0);
    qif.ready = 0; l2_valid = 0;
    tick();

    // Reset mid-burst
    l1_valid = 1; l1_base_addr = 16'h0000; l1_addr = 16'h0777; l1_xfer_len = 3;
    tick();
    qif.ready = 1;
    tick();
    check("s6_mid_busy", busy, 1);
    rst_n = 0; qif.ready = 0;
    tick();
    check("s6_rst_busy", busy, 0);
    check("s6_rst_valid", qif.valid, 0);
    rst_n = 1; l1_xfer_len = 0;
    tick();
    check("s6_regrant_valid", qif.valid, 1);
    check("s6_regrant_addr", qif.addr, 24'h000777);
    qif.ready = 1;
    tick();
    check("s6_done_busy", busy, 0);
    qif.ready = 0; l1_valid = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
